// File: rtl/rv32i_single_cycle_soc.sv
// Single-cycle RV32I core with one unified word-addressed RAM for code and data.
// Ports:
//   sysClk - system clock; PC, register file and RAM writes update on its rising edge
//   sysRes - asynchronous active-low reset; clears PC and x1..x31, leaves RAM intact
// Internal bus instrBusData carries the instruction at the current PC for monitoring.
module rv32i_single_cycle_soc #(
  parameter int unsigned RAM_WORD_CNT = 4096,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input logic sysClk,
  input logic sysRes
);

  localparam int unsigned AW = (RAM_WORD_CNT > 1) ? $clog2(RAM_WORD_CNT) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] RAM [RAM_WORD_CNT];
  logic [31:0] regs [32];
  logic [31:0] pc;
  logic [31:0] instrBusData;

  // Combinational fetch; PC[1:0] and bits above the RAM size are ignored.
  assign instrBusData = RAM[pc[AW+1:2]];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instrBusData[6:0];
  assign rd     = instrBusData[11:7];
  assign funct3 = instrBusData[14:12];
  assign rs1    = instrBusData[19:15];
  assign rs2    = instrBusData[24:20];
  assign funct7 = instrBusData[31:25];

  assign imm_i = {{20{instrBusData[31]}}, instrBusData[31:20]};
  assign imm_s = {{20{instrBusData[31]}}, instrBusData[31:25], instrBusData[11:7]};
  assign imm_b = {{19{instrBusData[31]}}, instrBusData[31], instrBusData[7],
                  instrBusData[30:25], instrBusData[11:8], 1'b0};
  assign imm_u = {instrBusData[31:12], 12'b0};
  assign imm_j = {{11{instrBusData[31]}}, instrBusData[31], instrBusData[19:12],
                  instrBusData[20], instrBusData[30:21], 1'b0};

  // Register read ports; x0 is hard-wired to zero.
  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // ALU shared by OP and OP-IMM.
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        is_sub;
  assign alu_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt  = alu_b[4:0];
  assign is_sub = (opcode == OPC_OP) && funct7[5];

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = is_sub ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  // Encodings outside RV32I (e.g. M-extension funct7) must not retire as ALU ops.
  logic alu_valid;
  always_comb begin
    alu_valid = 1'b0;
    if (opcode == OPC_OP) begin
      alu_valid = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else begin
      case (funct3)
        3'b001:  alu_valid = (funct7 == 7'b0000000);
        3'b101:  alu_valid = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        default: alu_valid = 1'b1;
      endcase
    end
  end

  // Branch condition.
  logic br_eq, br_lt, br_ltu, br_taken;
  assign br_eq  = (rs1_val == rs2_val);
  assign br_lt  = $signed(rs1_val) < $signed(rs2_val);
  assign br_ltu = rs1_val < rs2_val;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Data port: one address adder serves loads (imm_i) and stores (imm_s).
  logic [31:0] mem_addr, ld_word, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_valid;
  assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign ld_word  = RAM[mem_addr[AW+1:2]];
  assign ld_half  = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    case (mem_addr[1:0])
      2'b00:   ld_byte = ld_word[7:0];
      2'b01:   ld_byte = ld_word[15:8];
      2'b10:   ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
  end

  always_comb begin
    ld_val   = ld_word;
    ld_valid = 1'b1;
    case (funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = ld_word;
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_valid = 1'b0;
    endcase
  end

  // Next-state decode: PC target, register writeback and store lanes.
  logic [31:0] pc_plus4, next_pc, rd_val, mem_wdata;
  logic        rd_we;
  logic [3:0]  mem_be;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc   = pc_plus4;
    rd_we     = 1'b0;
    rd_val    = alu_res;
    mem_be    = 4'b0000;
    mem_wdata = rs2_val;
    case (opcode)
      OPC_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OPC_LOAD: begin
        rd_we  = ld_valid;
        rd_val = ld_val;
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: begin
            mem_be    = 4'b0001 << mem_addr[1:0];
            mem_wdata = {4{rs2_val[7:0]}};
          end
          3'b001: begin
            mem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{rs2_val[15:0]}};
          end
          3'b010:  mem_be = 4'b1111;
          default: mem_be = 4'b0000;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        rd_we = alu_valid;
      end
      default: ;
    endcase
  end

  // A store issued while reset is held must not reach RAM.
  logic [3:0] ram_be;
  assign ram_be = sysRes ? mem_be : 4'b0000;

  // PC and register file.
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge sysClk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_be[b]) RAM[mem_addr[AW+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[31:AW+2], mem_addr[31:AW+2]};

endmodule

// File: tb/tb_rv32i_single_cycle_soc.sv
// Directed bench for rv32i_single_cycle_soc: preloads RAM, runs short programs,
// checks architectural state and the fetched-instruction bus.
module tb_rv32i_single_cycle_soc;

  logic sysClk;
  logic sysRes;
  int   tests;
  int   fails;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  rv32i_single_cycle_soc dut (
    .sysClk(sysClk),
    .sysRes(sysRes)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Assert reset and refill the whole RAM with NOPs.
  task automatic enter_reset_and_clear;
    sysRes = 1'b0;
    for (int i = 0; i < 4096; i++) dut.RAM[i] <= NOP;
    #1;
  endtask

  task automatic put(input int idx, input logic [31:0] val);
    dut.RAM[idx] <= val;
    #0;
  endtask

  task automatic release_reset;
    @(negedge sysClk);
    sysRes = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  initial begin
    bit done;
    bit saw_ebreak;
    tests  = 0;
    fails  = 0;
    sysRes = 1'b0;

    // Reset and first fetch.
    enter_reset_and_clear();
    put(0, 32'h0050_0093);
    put(1, ECALL);
    step(2);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_x1", dut.regs[1], 32'h0);
    release_reset();
    check("fetch_first", dut.instrBusData, 32'h0050_0093);
    step(1);
    check("addi_x1", dut.regs[1], 32'd5);
    check("fetch_second", dut.instrBusData, ECALL);

    // ALU and x0.
    enter_reset_and_clear();
    put(0, enc_i(12'hFFF, 0, 0, 2, 7'h13));
    put(1, enc_i(12'h404, 2, 5, 3, 7'h13));
    put(2, enc_i(12'd28, 2, 5, 4, 7'h13));
    put(3, enc_r(7'h00, 2, 0, 3, 5));
    put(4, enc_r(7'h00, 2, 0, 2, 6));
    put(5, enc_i(12'd7, 0, 0, 0, 7'h13));
    put(6, enc_r(7'h20, 2, 0, 0, 7));
    put(7, enc_r(7'h00, 0, 0, 0, 8));
    put(8, ECALL);
    release_reset();
    step(8);
    check("addi_neg", dut.regs[2], 32'hFFFF_FFFF);
    check("srai", dut.regs[3], 32'hFFFF_FFFF);
    check("srli", dut.regs[4], 32'h0000_000F);
    check("sltu", dut.regs[5], 32'd1);
    check("slt", dut.regs[6], 32'd0);
    check("x0_store", dut.regs[0], 32'd0);
    check("sub", dut.regs[7], 32'd1);
    check("x0_read", dut.regs[8], 32'd0);
    check("alu_end", dut.instrBusData, ECALL);

    // Loads and stores.
    enter_reset_and_clear();
    put(0, {20'h87654, 5'd1, 7'h37});
    put(1, enc_i(12'h321, 1, 0, 1, 7'h13));
    put(2, enc_i(12'h100, 0, 0, 2, 7'h13));
    put(3, enc_s(12'd0, 1, 2, 3'd2));
    put(4, enc_i(12'd3, 2, 3'd0, 3, 7'h03));
    put(5, enc_i(12'd3, 2, 3'd4, 4, 7'h03));
    put(6, enc_i(12'd2, 2, 3'd1, 5, 7'h03));
    put(7, enc_i(12'hAA, 0, 0, 6, 7'h13));
    put(8, enc_s(12'd1, 6, 2, 3'd0));
    put(9, enc_i(12'd0, 2, 3'd2, 7, 7'h03));
    put(10, enc_i(12'd1, 2, 3'd5, 8, 7'h03));
    put(11, enc_s(12'd3, 6, 2, 3'd1));
    put(12, enc_i(12'd0, 2, 3'd2, 9, 7'h03));
    put(13, ECALL);
    release_reset();
    step(4);
    check("sw_word", dut.RAM[64], 32'h8765_4321);
    step(9);
    check("lb", dut.regs[3], 32'hFFFF_FF87);
    check("lbu", dut.regs[4], 32'h0000_0087);
    check("lh", dut.regs[5], 32'hFFFF_8765);
    check("sb_lw", dut.regs[7], 32'h8765_AA21);
    check("lhu_odd", dut.regs[8], 32'h0000_AA21);
    check("sh_lw", dut.regs[9], 32'h00AA_AA21);
    check("mem_end", dut.instrBusData, ECALL);

    // Branches and jumps.
    enter_reset_and_clear();
    put(0, enc_i(12'd1, 0, 0, 1, 7'h13));
    put(1, enc_i(12'hFFF, 0, 0, 2, 7'h13));
    put(2, enc_b(13'd8, 1, 1, 3'd0));
    put(3, enc_i(12'd99, 0, 0, 10, 7'h13));
    put(4, enc_b(13'd8, 2, 1, 3'd6));
    put(5, enc_i(12'd99, 0, 0, 11, 7'h13));
    put(6, enc_b(13'd8, 2, 1, 3'd4));
    put(7, enc_i(12'd7, 0, 0, 12, 7'h13));
    put(8, enc_j(21'd8, 1));
    put(9, enc_i(12'd99, 0, 0, 13, 7'h13));
    put(10, enc_i(12'h040, 0, 0, 1, 7'h13));
    put(11, enc_i(12'd1, 1, 0, 0, 7'h67));
    put(12, enc_i(12'd99, 0, 0, 14, 7'h13));
    put(16, enc_i(12'd3, 0, 0, 15, 7'h13));
    put(17, ECALL);
    release_reset();
    step(3);
    check("beq_taken_pc", dut.pc, 32'h10);
    step(1);
    check("bltu_taken_pc", dut.pc, 32'h18);
    step(1);
    check("blt_not_taken_pc", dut.pc, 32'h1C);
    step(2);
    check("jal_pc", dut.pc, 32'h28);
    check("jal_link", dut.regs[1], 32'h24);
    step(2);
    check("jalr_pc", dut.pc, 32'h40);
    step(1);
    check("beq_skip", dut.regs[10], 32'd0);
    check("bltu_skip", dut.regs[11], 32'd0);
    check("blt_fall", dut.regs[12], 32'd7);
    check("jal_skip", dut.regs[13], 32'd0);
    check("jalr_skip", dut.regs[14], 32'd0);
    check("jalr_target", dut.regs[15], 32'd3);
    check("br_end", dut.instrBusData, ECALL);

    // Self-checking program: sum 1..10, ECALL on pass, EBREAK on fail.
    enter_reset_and_clear();
    put(0, enc_i(12'd0, 0, 0, 1, 7'h13));
    put(1, enc_i(12'd10, 0, 0, 2, 7'h13));
    put(2, enc_r(7'h00, 2, 1, 0, 1));
    put(3, enc_i(12'hFFF, 2, 0, 2, 7'h13));
    put(4, enc_b(13'h1FF8, 0, 2, 3'd1));
    put(5, enc_i(12'd55, 0, 0, 3, 7'h13));
    put(6, enc_b(13'd16, 3, 1, 3'd1));
    put(7, enc_i(12'd56, 1, 3'd2, 4, 7'h13));
    put(8, enc_b(13'd8, 0, 4, 3'd0));
    put(9, ECALL);
    put(10, EBREAK);
    release_reset();
    done       = 1'b0;
    saw_ebreak = 1'b0;
    for (int c = 0; c < 50000 && !done; c++) begin
      if (dut.instrBusData === EBREAK) begin
        saw_ebreak = 1'b1;
        done       = 1'b1;
      end else if (dut.instrBusData === ECALL) begin
        done = 1'b1;
      end else begin
        step(1);
      end
    end
    check("prog_reached_ecall", dut.instrBusData, ECALL);
    check("prog_no_ebreak", 32'(saw_ebreak), 32'd0);
    check("prog_sum", dut.regs[1], 32'd55);

    // Store suppressed under reset, then asynchronous reset mid-run.
    enter_reset_and_clear();
    put(0, enc_s(12'h200, 0, 0, 3'd2));
    put(1, enc_i(12'd5, 0, 0, 1, 7'h13));
    put(128, 32'hDEAD_BEEF);
    step(3);
    check("reset_store_blocked", dut.RAM[128], 32'hDEAD_BEEF);
    release_reset();
    step(1);
    check("store_after_release", dut.RAM[128], 32'h0);
    step(11);
    check("midrun_pc", dut.pc, 32'h30);
    check("midrun_x1", dut.regs[1], 32'd5);
    #2;
    sysRes = 1'b0;
    #1;
    check("async_pc", dut.pc, 32'h0);
    check("async_x1", dut.regs[1], 32'h0);
    check("async_fetch", dut.instrBusData, enc_s(12'h200, 0, 0, 3'd2));
    release_reset();
    step(1);
    check("restart_pc", dut.pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
